// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache/main-memory arbiter:
// FSM state encoding, default block geometry and memory latency,
// block-alignment mask and the one-hot grant bit positions.
package cache_arb_pkg;

  localparam int unsigned MEM_LAT_DEF   = 4;
  localparam int unsigned BLK_WORDS_DEF = 8;
  localparam logic [15:0] BLK_MASK      = 16'hFFF0;

  // One-hot grant vector bit positions.
  localparam int GNT_I  = 0;
  localparam int GNT_D  = 1;
  localparam int GNT_WR = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } arb_state_e;

  // Block base address of a faulting byte address.
  function automatic logic [15:0] blk_base(input logic [15:0] addr);
    return addr & BLK_MASK;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_arb_grant.sv
// Grant selection for the cache/main-memory arbiter.
// Write-through stores always win. Between the two miss sides the
// loser of a tie is the side named by last_gnt_d_i (1 = D won last
// time, so I wins now); tying last_gnt_d_i low gives fixed D-first.
module arb_grant
  import cache_arb_pkg::*;
(
  input  logic       wr_req_i,
  input  logic       d_req_i,
  input  logic       i_req_i,
  input  logic       last_gnt_d_i,
  output logic [2:0] gnt_o
);

  // Priority pick: store, then miss tie-break, then single miss.
  always_comb begin
    gnt_o = 3'b000;
    if (wr_req_i) begin
      gnt_o[GNT_WR] = 1'b1;
    end else if (d_req_i && i_req_i) begin
      if (last_gnt_d_i) gnt_o[GNT_I] = 1'b1;
      else              gnt_o[GNT_D] = 1'b1;
    end else if (d_req_i) begin
      gnt_o[GNT_D] = 1'b1;
    end else if (i_req_i) begin
      gnt_o[GNT_I] = 1'b1;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbiter between I-cache block fills, D-cache block fills and D-side
// write-through stores onto a single main-memory port.
// Build option: define ARB_RR_EN to make I/D miss ties round-robin;
// without it D misses always beat I misses.
//
// Handshake: requests (i_miss, d_miss, d_wr_req) are levels with no
// ready/ack. A request is taken in the IDLE cycle it is seen; the
// address/data are latched on that grant edge and never resampled, so
// a request may drop mid-operation without aborting it. The stalls are
// the only back-pressure. Memory reads are pipelined: one issue per
// cycle, each answered by a single-cycle mem_valid MEM_LAT cycles later.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT   = MEM_LAT_DEF,
  parameter int unsigned BLK_WORDS = BLK_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_data_we,
  output logic        i_tag_we,
  output logic        d_data_we,
  output logic        d_tag_we,
  output logic        i_stall,
  output logic        d_stall,
  output arb_state_e  state_dbg
);

  localparam logic [2:0] LAST_IDX = 3'(BLK_WORDS - 1);
  localparam logic [7:0] LAT_LIM  = 8'(MEM_LAT);

  arb_state_e  state_q;
  logic [2:0]  issue_cnt_q;
  logic [2:0]  ret_cnt_q;
  logic [15:0] base_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic        mem_en_q;
  logic        mem_wr_q;
  logic [7:0]  lat_cnt_q;

  logic [2:0]  gnt;
  logic        last_gnt_d;
  logic [15:0] grant_base;
  logic [15:0] next_addr_d;
  logic        in_fill;
  logic        lat_ok;
  logic        ret_accept;
  logic        ret_last;

  arb_grant u_arb_grant (
    .wr_req_i     (d_wr_req),
    .d_req_i      (d_miss),
    .i_req_i      (i_miss),
    .last_gnt_d_i (last_gnt_d),
    .gnt_o        (gnt)
  );

`ifdef ARB_RR_EN
  logic last_gnt_d_q;

  // Remember which miss side won last so the other side wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_d_q <= 1'b0;
    end else if (state_q == IDLE && (gnt[GNT_D] || gnt[GNT_I])) begin
      last_gnt_d_q <= gnt[GNT_D];
    end
  end

  assign last_gnt_d = last_gnt_d_q;
`else
  assign last_gnt_d = 1'b0;
`endif

  // Block base of the winning miss and the address of the next issue.
  always_comb begin
    grant_base  = gnt[GNT_D] ? blk_base(d_miss_addr) : blk_base(i_miss_addr);
    next_addr_d = base_q + {12'd0, 3'(issue_cnt_q + 3'd1), 1'b0};
  end

  // Return acceptance: only during a fill, and never earlier than the
  // memory latency allows after the first issue.
  always_comb begin
    in_fill    = (state_q == I_FILL) || (state_q == D_FILL);
    lat_ok     = (lat_cnt_q >= LAT_LIM);
    ret_accept = in_fill && mem_valid && lat_ok;
    ret_last   = ret_accept && (ret_cnt_q == LAST_IDX);
  end

  // Main FSM: grant, issue the block reads, count returns, or do one store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= 3'd0;
      ret_cnt_q   <= 3'd0;
      base_q      <= 16'd0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 16'd0;
      lat_cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt[GNT_WR]) begin
            state_q     <= D_WRITE;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= d_wr_addr;
            mem_wdata_q <= d_wr_data;
          end else if (gnt[GNT_D] || gnt[GNT_I]) begin
            state_q     <= gnt[GNT_D] ? D_FILL : I_FILL;
            base_q      <= grant_base;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= grant_base;
            issue_cnt_q <= 3'd0;
            ret_cnt_q   <= 3'd0;
            lat_cnt_q   <= 8'd0;
          end
        end
        I_FILL, D_FILL: begin
          if (mem_en_q) begin
            if (issue_cnt_q == LAST_IDX) begin
              mem_en_q    <= 1'b0;
              mem_addr_q  <= 16'd0;
              issue_cnt_q <= 3'd0;
            end else begin
              issue_cnt_q <= issue_cnt_q + 3'd1;
              mem_addr_q  <= next_addr_d;
            end
          end
          if (lat_cnt_q != LAT_LIM) begin
            lat_cnt_q <= lat_cnt_q + 8'd1;
          end
          if (ret_accept) begin
            if (ret_last) begin
              ret_cnt_q <= 3'd0;
              state_q   <= IDLE;
            end else begin
              ret_cnt_q <= ret_cnt_q + 3'd1;
            end
          end
        end
        D_WRITE: begin
          mem_en_q    <= 1'b0;
          mem_wr_q    <= 1'b0;
          mem_addr_q  <= 16'd0;
          mem_wdata_q <= 16'd0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Fill strobes follow mem_valid in the same cycle; tag on the last word.
  always_comb begin
    fill_data = ret_accept ? mem_rdata : 16'd0;
    fill_word = ret_accept ? ret_cnt_q : 3'd0;
    i_data_we = ret_accept && (state_q == I_FILL);
    d_data_we = ret_accept && (state_q == D_FILL);
    i_tag_we  = ret_last && (state_q == I_FILL);
    d_tag_we  = ret_last && (state_q == D_FILL);
  end

  // Stalls: a lone store is released in its own D_WRITE cycle.
  always_comb begin
    i_stall = i_miss || (state_q == I_FILL);
    if (state_q == D_WRITE) d_stall = !(d_wr_req && !d_miss);
    else                    d_stall = d_miss || d_wr_req || (state_q == D_FILL);
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios, a cycle-indexed
// expectation schedule built from the block-fill timing rules, an
// expected fill-data queue, and a main-memory responder.
module tb_cache_mem_arbiter;
  import cache_arb_pkg::*;

  localparam int MEM_LAT = 4;
  localparam int BLK     = 8;
  localparam int NC      = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic        mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [2:0]  fill_word;
  logic        i_data_we, i_tag_we, d_data_we, d_tag_we, i_stall, d_stall;
  arb_state_e  state_dbg;

  logic        resp_valid = 1'b0, stray_valid = 1'b0;
  logic [15:0] resp_data = '0;
  assign mem_valid = resp_valid | stray_valid;
  assign mem_rdata = resp_valid ? resp_data : 16'hDEAD;

  cache_mem_arbiter #(.MEM_LAT(MEM_LAT), .BLK_WORDS(BLK)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_data_we(i_data_we), .i_tag_we(i_tag_we),
    .d_data_we(d_data_we), .d_tag_we(d_tag_we),
    .i_stall(i_stall), .d_stall(d_stall),
    .state_dbg(state_dbg)
  );

  // ---------------- memory contents ----------------
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a ^ 16'h5A5A) + 16'h0123;
  endfunction

  // ---------------- memory responder ----------------
  typedef struct { int due; logic [15:0] addr; } ret_t;
  ret_t rq[$];

  always @(posedge clk) begin
    #1;
    if (mem_en && !mem_wr) rq.push_back('{due: cyc + MEM_LAT, addr: mem_addr});
    resp_valid = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      resp_valid = 1'b1;
      resp_data  = mem_word(rq[0].addr);
      void'(rq.pop_front());
    end
  end

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  bit          x_en[NC], x_wr[NC], x_istb[NC], x_dstb[NC], x_itag[NC], x_dtag[NC];
  bit          x_ibusy[NC], x_dfill[NC], x_dwr[NC];
  logic [15:0] x_addr[NC], x_wdata[NC];
  logic [2:0]  x_word[NC];
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Request seen in IDLE during cycle c: grant edge ends cycle c, issue k
  // (0-based) lands in cycle c+1+k, its data MEM_LAT cycles later.
  task automatic sched_fill(input bit is_d, input logic [15:0] base, input int c);
    for (int k = 0; k < BLK; k++) begin
      int ic, rc;
      ic = c + 1 + k;
      rc = ic + MEM_LAT;
      x_en[ic]   = 1'b1;
      x_wr[ic]   = 1'b0;
      x_addr[ic] = base + 16'(2 * k);
      if (is_d) x_dstb[rc] = 1'b1; else x_istb[rc] = 1'b1;
      x_word[rc] = 3'(k);
      if (k == BLK - 1) begin
        if (is_d) x_dtag[rc] = 1'b1; else x_itag[rc] = 1'b1;
      end
      exp_q.push_back(mem_word(base + 16'(2 * k)));
    end
    for (int p = c + 1; p <= c + BLK + MEM_LAT; p++) begin
      if (is_d) x_dfill[p] = 1'b1; else x_ibusy[p] = 1'b1;
    end
  endtask

  task automatic sched_write(input logic [15:0] a, input logic [15:0] d, input int c);
    x_en[c + 1]    = 1'b1;
    x_wr[c + 1]    = 1'b1;
    x_addr[c + 1]  = a;
    x_wdata[c + 1] = d;
    x_dwr[c + 1]   = 1'b1;
  endtask

  // Reset wipes everything still pending from cycle c onward.
  task automatic abort_from(input int c);
    for (int p = c; p < NC; p++) begin
      x_en[p] = 0; x_wr[p] = 0; x_istb[p] = 0; x_dstb[p] = 0; x_itag[p] = 0;
      x_dtag[p] = 0; x_ibusy[p] = 0; x_dfill[p] = 0; x_dwr[p] = 0;
    end
    exp_q.delete();
  endtask

  // Per-cycle comparison of every output against the schedule.
  always @(negedge clk) begin : compare
    int c;
    logic exp_dst;
    arb_state_e es;
    c = cyc;
    if (c > 0 && c < NC) begin
      chk("mem_en", 16'(mem_en), 16'(x_en[c]));
      if (x_en[c]) begin
        chk("mem_wr", 16'(mem_wr), 16'(x_wr[c]));
        chk("mem_addr", mem_addr, x_addr[c]);
        if (x_wr[c]) chk("mem_wdata", mem_wdata, x_wdata[c]);
      end
      chk("i_data_we", 16'(i_data_we), 16'(x_istb[c]));
      chk("d_data_we", 16'(d_data_we), 16'(x_dstb[c]));
      chk("i_tag_we", 16'(i_tag_we), 16'(x_itag[c]));
      chk("d_tag_we", 16'(d_tag_we), 16'(x_dtag[c]));
      if (x_istb[c] || x_dstb[c]) begin
        chk("fill_word", 16'(fill_word), 16'(x_word[c]));
        if (exp_q.size() == 0) chk("fill_data_expected", 16'd0, 16'd1);
        else chk("fill_data", fill_data, exp_q.pop_front());
      end
      chk("i_stall", 16'(i_stall), 16'(i_miss | x_ibusy[c]));
      if (x_dwr[c]) exp_dst = !(d_wr_req && !d_miss);
      else          exp_dst = d_miss | d_wr_req | x_dfill[c];
      chk("d_stall", 16'(d_stall), 16'(exp_dst));
      es = IDLE;
      if (x_ibusy[c])      es = I_FILL;
      else if (x_dfill[c]) es = D_FILL;
      else if (x_dwr[c])   es = D_WRITE;
      chk("state", 16'(state_dbg), 16'(es));
    end
  end

  // Strobe monitor for the reset-abort window.
  bit mon_en = 1'b0;
  int mon_hits = 0;
  always @(negedge clk) begin
    if (mon_en && (i_data_we || i_tag_we || d_data_we || d_tag_we)) mon_hits++;
  end

  // ---------------- driver ----------------
  task automatic go_to(input int p);
    while (cyc < p) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin : watchdog
    #(NC * 10);
    $display("FAIL watchdog: cycle budget %0d exhausted", NC);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset: outputs idle, stall follows the request combinationally.
    go_to(2);
    i_miss = 1'b1;
    @(negedge clk);
    chk("rst_i_stall", 16'(i_stall), 16'd1);
    chk("rst_mem_en", 16'(mem_en), 16'd0);
    chk("rst_fill_word", 16'(fill_word), 16'd0);
    chk("rst_state", 16'(state_dbg), 16'(IDLE));
    go_to(3);
    i_miss = 1'b0;
    go_to(4);
    rst_n = 1'b1;

    // D fill whose request drops after three cycles: it still completes.
    go_to(10);
    d_miss = 1'b1; d_miss_addr = 16'h4016;
    sched_fill(1'b1, 16'h4010, 10);
    go_to(13);
    d_miss = 1'b0;

    // I fill at 0x0046; address changes after grant must be ignored.
    go_to(30);
    i_miss = 1'b1; i_miss_addr = 16'h0046;
    sched_fill(1'b0, 16'h0040, 30);
    go_to(31);
    i_miss_addr = 16'h7777;
    @(negedge clk);
    chk("i_first_addr", mem_addr, 16'h0040);
    go_to(38);
    @(negedge clk);
    chk("i_last_addr", mem_addr, 16'h004E);
    go_to(39);
    @(negedge clk);
    chk("i_issue_done", 16'(mem_en), 16'd0);
    go_to(42);
    i_miss = 1'b0;
    @(negedge clk);
    chk("i_tag_cycle12", 16'(i_tag_we), 16'd1);
    chk("i_tag_word", 16'(fill_word), 16'd7);
    chk("i_stall_fill", 16'(i_stall), 16'd1);
    go_to(43);
    @(negedge clk);
    chk("i_stall_released", 16'(i_stall), 16'd0);

    // Simultaneous misses: D at 0x2200 first, then I at 0x0100.
    go_to(50);
    i_miss = 1'b1; i_miss_addr = 16'h0100;
    d_miss = 1'b1; d_miss_addr = 16'h2208;
    sched_fill(1'b1, 16'h2200, 50);
    sched_fill(1'b0, 16'h0100, 63);
    go_to(62);
    d_miss = 1'b0;
    @(negedge clk);
    chk("d_tag", 16'(d_tag_we), 16'd1);
    go_to(63);
    @(negedge clk);
    chk("idle_between", 16'(state_dbg), 16'(IDLE));
    go_to(64);
    @(negedge clk);
    chk("i_after_d_addr", mem_addr, 16'h0100);
    go_to(75);
    i_miss = 1'b0;

    // Lone write-through store.
    go_to(80);
    d_wr_req = 1'b1; d_wr_addr = 16'h3002; d_wr_data = 16'hBEEF;
    sched_write(16'h3002, 16'hBEEF, 80);
    go_to(81);
    @(negedge clk);
    chk("wr_mem_wr", 16'(mem_wr), 16'd1);
    chk("wr_addr", mem_addr, 16'h3002);
    chk("wr_data", mem_wdata, 16'hBEEF);
    chk("wr_d_stall", 16'(d_stall), 16'd0);
    go_to(82);
    d_wr_req = 1'b0;
    @(negedge clk);
    chk("wr_back_idle", 16'(state_dbg), 16'(IDLE));
    chk("wr_en_low", 16'(mem_en), 16'd0);

    // Store and load miss together: store first, then the fill.
    go_to(85);
    d_wr_req = 1'b1; d_wr_addr = 16'h5554; d_wr_data = 16'h1234;
    d_miss = 1'b1; d_miss_addr = 16'h6002;
    sched_write(16'h5554, 16'h1234, 85);
    sched_fill(1'b1, 16'h6000, 87);
    go_to(86);
    d_wr_req = 1'b0;
    go_to(99);
    d_miss = 1'b0;

    // Stray mem_valid while idle.
    go_to(105);
    stray_valid = 1'b1;
    @(negedge clk);
    chk("stray_i_we", 16'(i_data_we), 16'd0);
    chk("stray_d_we", 16'(d_data_we), 16'd0);
    chk("stray_state", 16'(state_dbg), 16'(IDLE));
    go_to(106);
    stray_valid = 1'b0;

    // Reset in cycle 6 of an I fill: abort, late returns ignored.
    go_to(110);
    i_miss = 1'b1; i_miss_addr = 16'h0A0C;
    sched_fill(1'b0, 16'h0A00, 110);
    go_to(116);
    rst_n = 1'b0; i_miss = 1'b0;
    abort_from(116);
    mon_hits = 0; mon_en = 1'b1;
    go_to(117);
    rst_n = 1'b1;
    go_to(130);
    mon_en = 1'b0;
    chk("abort_no_strobes", 16'(mon_hits), 16'd0);

    // Fresh reset, then three fills with both misses held high.
    go_to(135);
    rst_n = 1'b0;
    abort_from(135);
    go_to(137);
    rst_n = 1'b1;
    go_to(140);
    i_miss = 1'b1; i_miss_addr = 16'h0100;
    d_miss = 1'b1; d_miss_addr = 16'h2208;
    sched_fill(1'b1, 16'h2200, 140);
`ifdef ARB_RR_EN
    sched_fill(1'b0, 16'h0100, 153);
`else
    sched_fill(1'b1, 16'h2200, 153);
`endif
    sched_fill(1'b1, 16'h2200, 166);
    go_to(154);
    @(negedge clk);
`ifdef ARB_RR_EN
    chk("second_grant_addr", mem_addr, 16'h0100);
`else
    chk("second_grant_addr", mem_addr, 16'h2200);
`endif
    go_to(178);
    i_miss = 1'b0; d_miss = 1'b0;
    go_to(185);

    chk("exp_q_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
